// File: rtl/gps_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gps_cfg_pkg : shared types, PMTK command ROM and ack string for the GNSS   |
// |               configuration controller (watchdog macro: GPS_CFG_WDOG_EN).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package gps_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_NEXT     = 3'd4,
        ST_RUN      = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

    localparam int CMD_NUM  = 2;
    localparam int CMD0_LEN = 18;
    localparam int CMD1_LEN = 51;

    // First character sits in the most significant byte of each string.
    localparam logic [8*CMD0_LEN-1:0] CMD0_STR = {"$PMTK220,1000*1F", 8'h0D, 8'h0A};
    localparam logic [8*CMD1_LEN-1:0] CMD1_STR = {"$PMTK314,0,1,", "0,0,0,0,0,",
                                                  "0,0,0,0,0,", "0,0,0,0,0,",
                                                  "0,0*29", 8'h0D, 8'h0A};

    localparam logic [7:0] CMD_LEN [CMD_NUM] = '{8'd18, 8'd51};

    localparam logic [63:0] ACK_STR = "$PMTK001";

    function automatic logic [7:0] cmd_len(input logic [1:0] idx);
        return (idx == 2'd0) ? CMD_LEN[0] : CMD_LEN[1];
    endfunction

    function automatic logic [7:0] rom_byte(input logic [1:0] idx, input logic [7:0] ptr);
        logic [8*CMD0_LEN-1:0] t0;
        logic [8*CMD1_LEN-1:0] t1;
        t0 = CMD0_STR << (8 * ptr);
        t1 = CMD1_STR << (8 * ptr);
        return (idx == 2'd0) ? t0[8*CMD0_LEN-1 -: 8] : t1[8*CMD1_LEN-1 -: 8];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gps_ack_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gps_ack_det : spots "$PMTK001" in the UART receive stream and emits a      |
// |               one-cycle registered hit pulse.                              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module gps_ack_det
    import gps_cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] po_data_i,
    input  logic       po_flag_i,
    output logic       hit_o
);

    logic [63:0] sh_q, sh_d;
    logic        hit_q;

    // A '$' starts a fresh sentence, so older bytes can never join a match.
    always_comb begin
        sh_d = sh_q;
        if (po_flag_i) begin
            if (po_data_i == 8'h24) begin
                sh_d = {56'd0, po_data_i};
            end else begin
                sh_d = {sh_q[55:0], po_data_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            hit_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            hit_q <= po_flag_i && (sh_d == ACK_STR);
        end
    end

    assign hit_o = hit_q;

endmodule
`default_nettype wire

// File: rtl/gps_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gps_cfg_ctrl : sends PMTK setup commands, waits for acks with retry, then  |
// |                enables the time parser. GPS_CFG_WDOG_EN adds a watchdog.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module gps_cfg_ctrl
    import gps_cfg_pkg::*;
#(
    parameter int unsigned PWR_DLY   = 50_000_000,
    parameter int unsigned ACK_TO    = 25_000_000,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned WDOG_TO   = 150_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] po_data,
    input  logic       po_flag,
    input  logic       sentence_ok,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       parser_en,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [1:0] cmd_idx
);

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [31:0] retry_q;
    logic [7:0]  byte_ptr_q;
    logic [1:0]  cmd_idx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        parser_en_q;
    logic        cfg_done_q;
    logic        cfg_err_q;
`ifdef GPS_CFG_WDOG_EN
    logic [31:0] wdog_q;
`else
    wire         w_unused_ok = sentence_ok | (WDOG_TO == 32'd0);
`endif

    logic w_ack_hit;
    logic w_accept;

    assign w_accept = tx_valid_q && tx_ready;

    gps_ack_det u_ack_det (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .po_data_i (po_data),
        .po_flag_i (po_flag),
        .hit_o     (w_ack_hit)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            byte_ptr_q  <= '0;
            cmd_idx_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            parser_en_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef GPS_CFG_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_PWR_WAIT;
                    cnt_q   <= '0;
                end
                ST_PWR_WAIT: begin
                    if (cnt_q == 32'(PWR_DLY - 1)) begin
                        state_q    <= ST_SEND;
                        cnt_q      <= '0;
                        byte_ptr_q <= '0;
                        tx_data_q  <= rom_byte(cmd_idx_q, 8'd0);
                        tx_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                ST_SEND: begin
                    // tx_data only advances on acceptance, so a stall holds it.
                    if (w_accept) begin
                        if (byte_ptr_q == cmd_len(cmd_idx_q) - 8'd1) begin
                            state_q    <= ST_WAIT_ACK;
                            tx_valid_q <= 1'b0;
                            byte_ptr_q <= '0;
                            cnt_q      <= '0;
                        end else begin
                            byte_ptr_q <= byte_ptr_q + 8'd1;
                            tx_data_q  <= rom_byte(cmd_idx_q, byte_ptr_q + 8'd1);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_ack_hit) begin
                        state_q <= ST_NEXT;
                        retry_q <= '0;
                    end else if (cnt_q == 32'(ACK_TO - 1)) begin
                        if (retry_q < MAX_RETRY) begin
                            retry_q    <= sat_inc(retry_q);
                            state_q    <= ST_SEND;
                            byte_ptr_q <= '0;
                            tx_data_q  <= rom_byte(cmd_idx_q, 8'd0);
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ERROR;
                            cfg_err_q   <= 1'b1;
                            parser_en_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                ST_NEXT: begin
                    if (cmd_idx_q == 2'(CMD_NUM - 1)) begin
                        state_q     <= ST_RUN;
                        parser_en_q <= 1'b1;
                        cfg_done_q  <= 1'b1;
`ifdef GPS_CFG_WDOG_EN
                        wdog_q      <= '0;
`endif
                    end else begin
                        cmd_idx_q  <= cmd_idx_q + 2'd1;
                        state_q    <= ST_SEND;
                        byte_ptr_q <= '0;
                        tx_data_q  <= rom_byte(cmd_idx_q + 2'd1, 8'd0);
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef GPS_CFG_WDOG_EN
                    // A sentence on the expiry cycle still counts as alive.
                    if (sentence_ok) begin
                        wdog_q <= '0;
                    end else if (wdog_q == 32'(WDOG_TO - 1)) begin
                        state_q     <= ST_PWR_WAIT;
                        parser_en_q <= 1'b0;
                        cfg_done_q  <= 1'b0;
                        cmd_idx_q   <= '0;
                        retry_q     <= '0;
                        cnt_q       <= '0;
                        wdog_q      <= '0;
                    end else begin
                        wdog_q <= sat_inc(wdog_q);
                    end
`endif
                end
                ST_ERROR: begin
                    tx_valid_q  <= 1'b0;
                    parser_en_q <= 1'b0;
                    cfg_err_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign parser_en = parser_en_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign cmd_idx   = cmd_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gps_cfg_ctrl : directed self-checking bench for gps_cfg_ctrl.           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_gps_cfg_ctrl;

    localparam int unsigned PWR_DLY   = 10;
    localparam int unsigned ACK_TO    = 100;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned WDOG_TO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] po_data = 8'h00;
    logic       po_flag = 1'b0;
    logic       sentence_ok = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       parser_en;
    logic       cfg_done;
    logic       cfg_err;
    logic [1:0] cmd_idx;

    int n_chk = 0;
    int n_err = 0;

    gps_cfg_ctrl #(
        .PWR_DLY   (PWR_DLY),
        .ACK_TO    (ACK_TO),
        .MAX_RETRY (MAX_RETRY),
        .WDOG_TO   (WDOG_TO)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .po_data     (po_data),
        .po_flag     (po_flag),
        .sentence_ok (sentence_ok),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .parser_en   (parser_en),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cmd_idx     (cmd_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int cmd, input int i);
        string s;
        if (cmd == 0) begin
            s = "$PMTK220,1000*1F";
        end else begin
            s = "$PMTK314,0,1";
            for (int k = 0; k < 17; k++) s = {s, ",0"};
            s = {s, "*29"};
        end
        if (i < s.len()) return s[i];
        if (i == s.len()) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic int exp_len(input int cmd);
        return (cmd == 0) ? 18 : 51;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        po_data = b;
        po_flag = 1'b1;
        tick();
        po_flag = 1'b0;
        po_data = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Receives one full command; stall=1 inserts a not-ready cycle before each byte.
    task automatic recv_cmd(input int cmd, input bit stall);
        int w;
        w = 0;
        while (tx_valid !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        check("txv_wait", tx_valid, 1);
        if (tx_valid === 1'b1) begin
            for (int i = 0; i < exp_len(cmd); i++) begin
                check($sformatf("c%0d_b%0d", cmd, i), tx_data, exp_byte(cmd, i));
                if (stall) begin
                    tx_ready = 1'b0;
                    tick();
                    check($sformatf("stall_c%0d_b%0d", cmd, i), tx_data, exp_byte(cmd, i));
                    check("stall_valid", tx_valid, 1);
                end
                tx_ready = 1'b1;
                tick();
            end
            check("txv_done", tx_valid, 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 0);
        check("rst_pen", parser_en, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_idx", cmd_idx, 0);
        rst = 1'b0;

        // Power-up delay and first command
        repeat (10) tick();
        check("pre_first_txv", tx_valid, 0);
        tick();
        check("first_txv", tx_valid, 1);
        check("first_byte", tx_data, 8'h24);
        recv_cmd(0, 1'b0);
        check("idx_cmd0", cmd_idx, 0);

        // Ack cmd0; hold the transmitter so cmd1 waits for the receiver
        tx_ready = 1'b0;
        send_str("$PMTK001,220,3*30");
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("idx_cmd1", cmd_idx, 1);
        recv_cmd(1, 1'b1);

        // Split ack: no early hit
        send_str("$PMTK0$PMTK00");
        repeat (2) tick();
        check("early_done", cfg_done, 0);
        check("early_pen", parser_en, 0);
        send_byte("1");
        tick();
        check("run_lat", parser_en, 0);
        tick();
        check("run_pen", parser_en, 1);
        check("run_done", cfg_done, 1);
        check("run_idx", cmd_idx, 1);
        check("run_err", cfg_err, 0);
        check("run_txv", tx_valid, 0);
        send_str(",220,3*30");

`ifdef GPS_CFG_WDOG_EN
        for (int p = 0; p < 3; p++) begin
            repeat (149) tick();
            sentence_ok = 1'b1;
            tick();
            sentence_ok = 1'b0;
            check("wd_hold", parser_en, 1);
        end
        repeat (199) tick();
        sentence_ok = 1'b1;
        tick();
        sentence_ok = 1'b0;
        check("wd_tie", parser_en, 1);
        repeat (199) tick();
        check("wd_pre", parser_en, 1);
        tick();
        check("wd_expire_pen", parser_en, 0);
        check("wd_expire_done", cfg_done, 0);
        check("wd_expire_idx", cmd_idx, 0);
        tx_ready = 1'b0;
        repeat (9) tick();
        check("wd_pre_resend", tx_valid, 0);
        tick();
        check("wd_resend_txv", tx_valid, 1);
        check("wd_resend_byte", tx_data, 8'h24);
`endif

        // Reset in the middle of a command
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_ready = 1'b0;
        repeat (11) tick();
        check("mid_txv", tx_valid, 1);
        tx_ready = 1'b1;
        repeat (2) tick();
        check("mid_byte", tx_data, exp_byte(0, 2));
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid_txv", tx_valid, 0);
        check("rst_mid_txd", tx_data, 0);
        tick();
        rst = 1'b0;

        // Ack arriving during power-up wait must be ignored; then retries to error
        send_str("$PMTK001");
        repeat (2) tick();
        check("ign_pre_txv", tx_valid, 0);
        tick();
        check("ign_txv", tx_valid, 1);
        for (int r = 0; r < 4; r++) begin
            recv_cmd(0, 1'b0);
            repeat (99) tick();
            if (r < 3) begin
                check("to_pre", tx_valid, 0);
                tick();
                check("to_resend", tx_valid, 1);
                check("to_err", cfg_err, 0);
            end else begin
                check("err_pre", cfg_err, 0);
                tick();
                check("err_set", cfg_err, 1);
                check("err_pen", parser_en, 0);
                check("err_txv", tx_valid, 0);
                check("err_done", cfg_done, 0);
            end
        end
        repeat (300) tick();
        check("err_sticky", cfg_err, 1);
        check("err_idle_txv", tx_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
